// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Purpose : bundles the fetch-side and decode-side handshake of the 2-wide
//           instruction queue. The queue connects through the slave modport.
//           The fetch/decode environment connects through the master modport.
// Signals :
//   in_valid[2], in_pc[2], in_instr[2]     fetch slots (slot 1 = slot 0 + 4)
//   can_proceed[2]                         per-slot accept back to fetch
//   flush                                  taken branch, drain everything
//   out_valid[2], out_pc[2], out_instr[2]  two oldest entries to decode
//   out_ready[2]                           decode pops slot i
//   count                                  occupied entries
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]           in_valid;
  logic [1:0][XLEN-1:0] in_pc;
  logic [1:0][XLEN-1:0] in_instr;
  logic [1:0]           can_proceed;
  logic                 flush;
  logic [1:0]           out_valid;
  logic [1:0][XLEN-1:0] out_pc;
  logic [1:0][XLEN-1:0] out_instr;
  logic [1:0]           out_ready;
  logic [CW-1:0]        count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  can_proceed, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output can_proceed, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Purpose : 2-wide in-order instruction queue between fetch and decode.
//           Up to two {pc, instr} slots are accepted per cycle.
//           Up to two of the oldest entries are popped per cycle.
//           A flush empties the queue and drops the inputs and pops of that
//           cycle.
// Ports   :
//   clk    clock, all state updates on posedge
//   reset  asynchronous, active-low reset
//   fq     fetch_queue_if.slave (fetch slots, can_proceed, flush,
//          decode slots, out_ready, count)
// Config  : FETCH_QUEUE_BYPASS_EN -- when defined, an empty queue forwards
//           the fetch slots straight to the decode ports in the same cycle.
//           Bypassed slots that decode pops in that cycle are not stored.
//           Without it, every entry has a fixed 1-cycle latency.
// Also holds fetch_queue_chk, a simulation-only checker for fetch-side
// protocol misuse.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Storage has no reset; validity is tracked by count_r only.
  logic [XLEN-1:0]      pc_mem_r    [DEPTH];
  logic [XLEN-1:0]      instr_mem_r [DEPTH];

  logic [PW-1:0]        head_r;
  logic [PW-1:0]        tail_r;
  logic [CW-1:0]        count_r;
  logic [1:0]           can_proceed_r;
  logic [1:0]           valid_r;

  logic                 byp_s;
  logic                 e0_s, e1_s;
  logic                 d0_s, d1_s;
  logic                 wr0_s, wr1_s;
  logic                 pop0_s, pop1_s;
  logic [PW-1:0]        head1_s;
  logic [PW-1:0]        tail_wr1_s;
  logic [CW-1:0]        count_next_s;
  logic [1:0]           out_valid_s;
  logic [1:0][XLEN-1:0] rd_pc_s;
  logic [1:0][XLEN-1:0] rd_instr_s;

  // Free-slot test. Bit 1 set means two slots are free, bit 0 means one.
  function automatic logic [1:0] space_of(input logic [CW-1:0] cnt);
    logic [CW-1:0] free_v;
    free_v = CW'(DEPTH) - cnt;
    return {free_v >= {{(CW-2){1'b0}}, 2'd2}, free_v >= {{(CW-1){1'b0}}, 1'b1}};
  endfunction

  // Occupancy test that drives the registered decode-side valids.
  function automatic logic [1:0] valid_of(input logic [CW-1:0] cnt);
    return {cnt >= {{(CW-2){1'b0}}, 2'd2}, cnt >= {{(CW-1){1'b0}}, 1'b1}};
  endfunction

  // Handshake decode: accepts, pops, bypass selection and next occupancy.
  always_comb begin
    byp_s   = BYPASS_EN & (count_r == {CW{1'b0}}) & ~fq.flush;
    e0_s    = can_proceed_r[0] & fq.in_valid[0];
    // Slot 1 without slot 0 is never accepted.
    e1_s    = can_proceed_r[1] & fq.in_valid[1] & fq.in_valid[0];
    head1_s = head_r + {{(PW-1){1'b0}}, 1'b1};

    if (byp_s) begin
      out_valid_s = {fq.in_valid[1] & fq.in_valid[0], fq.in_valid[0]};
      rd_pc_s     = fq.in_pc;
      rd_instr_s  = fq.in_instr;
    end else begin
      out_valid_s   = valid_r;
      rd_pc_s[0]    = pc_mem_r[head_r];
      rd_pc_s[1]    = pc_mem_r[head1_s];
      rd_instr_s[0] = instr_mem_r[head_r];
      rd_instr_s[1] = instr_mem_r[head1_s];
    end

    d0_s = out_valid_s[0] & fq.out_ready[0];
    // Slot 1 can only be popped together with slot 0.
    d1_s = d0_s & out_valid_s[1] & fq.out_ready[1];

    if (byp_s) begin
      // Bypassed slots that decode takes this cycle never reach storage.
      // The empty queue has nothing to pop.
      wr0_s  = e0_s & ~d0_s;
      wr1_s  = e1_s & ~d1_s;
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end else begin
      wr0_s  = e0_s;
      wr1_s  = e1_s;
      pop0_s = d0_s;
      pop1_s = d1_s;
    end

    // Slot 1 goes to tail when slot 0 is not stored (bypass pop of slot 0).
    tail_wr1_s = tail_r + {{(PW-1){1'b0}}, wr0_s};

    if (fq.flush) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r
                   + {{(CW-1){1'b0}}, wr0_s} + {{(CW-1){1'b0}}, wr1_s}
                   - {{(CW-1){1'b0}}, pop0_s} - {{(CW-1){1'b0}}, pop1_s};
    end
  end

  // Decode-side data is zero whenever its slot is not valid.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (out_valid_s[i]) begin
        fq.out_pc[i]    = rd_pc_s[i];
        fq.out_instr[i] = rd_instr_s[i];
      end else begin
        fq.out_pc[i]    = {XLEN{1'b0}};
        fq.out_instr[i] = {XLEN{1'b0}};
      end
    end
  end

  assign fq.out_valid   = out_valid_s;
  assign fq.can_proceed = can_proceed_r;
  assign fq.count       = count_r;

  // Pointers, occupancy and the status flags derived from occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      can_proceed_r <= 2'b11;
      valid_r       <= 2'b00;
    end else begin
      if (fq.flush) begin
        head_r <= {PW{1'b0}};
        tail_r <= {PW{1'b0}};
      end else begin
        // Pointers are exactly PW bits wide, so they wrap modulo DEPTH.
        head_r <= head_r + {{(PW-1){1'b0}}, pop0_s} + {{(PW-1){1'b0}}, pop1_s};
        tail_r <= tail_r + {{(PW-1){1'b0}}, wr0_s} + {{(PW-1){1'b0}}, wr1_s};
      end
      count_r       <= count_next_s;
      can_proceed_r <= space_of(count_next_s);
      valid_r       <= valid_of(count_next_s);
    end
  end

  // Entry storage writes. A flush discards this cycle's fetch slots.
  always_ff @(posedge clk) begin
    if (!fq.flush) begin
      if (wr0_s) begin
        pc_mem_r[tail_r]    <= fq.in_pc[0];
        instr_mem_r[tail_r] <= fq.in_instr[0];
      end
      if (wr1_s) begin
        pc_mem_r[tail_wr1_s]    <= fq.in_pc[1];
        instr_mem_r[tail_wr1_s] <= fq.in_instr[1];
      end
    end
  end
endmodule

// ---------------------------------------------------------------------------
// fetch_queue_chk
// Purpose : flags fetch presenting slot 1 without slot 0. The queue ignores
//           that slot 1.
// Ports   : clk, reset (active-low), in_valid[2]
// ---------------------------------------------------------------------------
module fetch_queue_chk (
  input logic       clk,
  input logic       reset,
  input logic [1:0] in_valid
);
  // Slot 1 must never be valid on its own.
  a_slot1_needs_slot0: assert property (@(posedge clk) disable iff (!reset)
    !(in_valid[1] && !in_valid[0]));
endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Purpose : directed self-checking bench for fetch_queue (DEPTH=8, XLEN=32).
//           Covers reset, fill/backpressure, full-with-pop, partial pops,
//           data gating, flush, bypass-or-latency, ordered streaming across
//           pointer wrap, and asynchronous reset in mid-stream.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   popped;
  int   adv;
  logic [31:0] exp_out;
  logic [31:0] next_in;

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq.slave)
  );

  fetch_queue_chk chk_i (
    .clk      (clk),
    .reset    (reset),
    .in_valid (fq.in_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] iv, input logic [31:0] pc0,
                       input logic [1:0] ordy, input logic fl);
    fq.in_valid    = iv;
    fq.in_pc[0]    = pc0;
    fq.in_pc[1]    = pc0 + 32'd4;
    fq.in_instr[0] = instr_of(pc0);
    fq.in_instr[1] = instr_of(pc0 + 32'd4);
    fq.out_ready   = ordy;
    fq.flush       = fl;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    popped      = 0;
    reset       = 1'b0;
    drive(2'b00, 32'h0, 2'b00, 1'b0);

    // Reset state
    #12;
    chk("rst_count", 32'(fq.count), 32'd0);
    chk("rst_out_valid", 32'(fq.out_valid), 32'd0);
    chk("rst_can_proceed", 32'(fq.can_proceed), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fill with two slots per cycle, no pops
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'(8 * k), 2'b00, 1'b0);
      tick();
      chk("fill_count", 32'(fq.count), 32'(2 * k + 2));
    end
    chk("full_can_proceed", 32'(fq.can_proceed), 32'd0);
    chk("full_out_valid", 32'(fq.out_valid), 32'd3);

    // Full: decode pops two, fetch attempts to push but is refused
    drive(2'b11, 32'h300, 2'b11, 1'b0);
    #1;
    chk("full_out_pc0", fq.out_pc[0], 32'h0);
    chk("full_out_pc1", fq.out_pc[1], 32'h4);
    chk("full_out_instr0", fq.out_instr[0], instr_of(32'h0));
    tick();
    chk("full_pop_count", 32'(fq.count), 32'd6);

    drive(2'b01, 32'h20, 2'b00, 1'b0);
    tick();
    chk("cnt7_count", 32'(fq.count), 32'd7);
    chk("cnt7_can_proceed", 32'(fq.can_proceed), 32'd1);

    // Only slot 0 fits at count 7 (0x24 in, 0x28 dropped); tail wraps
    drive(2'b11, 32'h24, 2'b00, 1'b0);
    tick();
    chk("cnt8_count", 32'(fq.count), 32'd8);

    drive(2'b00, 32'h0, 2'b11, 1'b0);
    #1;
    chk("wrap_out_pc0", fq.out_pc[0], 32'h8);
    chk("wrap_out_pc1", fq.out_pc[1], 32'hC);
    tick();
    tick();
    chk("drain4_count", 32'(fq.count), 32'd4);
    drive(2'b00, 32'h0, 2'b01, 1'b0);
    tick();
    chk("cnt3_count", 32'(fq.count), 32'd3);
    chk("cnt3_out_pc0", fq.out_pc[0], 32'h1C);

    // Partial pop: ready on slot 1 only pops nothing
    drive(2'b00, 32'h0, 2'b10, 1'b0);
    tick();
    chk("rdy1_only_count", 32'(fq.count), 32'd3);
    chk("rdy1_only_pc0", fq.out_pc[0], 32'h1C);
    drive(2'b00, 32'h0, 2'b01, 1'b0);
    tick();
    chk("rdy0_only_count", 32'(fq.count), 32'd2);
    chk("rdy0_only_pc0", fq.out_pc[0], 32'h20);
    chk("rdy0_only_pc1", fq.out_pc[1], 32'h24);
    tick();
    chk("cnt1_count", 32'(fq.count), 32'd1);
    chk("cnt1_out_valid", 32'(fq.out_valid), 32'd1);
    chk("cnt1_pc0", fq.out_pc[0], 32'h24);
    chk("gate_pc1", fq.out_pc[1], 32'h0);
    chk("gate_instr1", fq.out_instr[1], 32'h0);

    // Flush at count 5 with inputs and pops active
    drive(2'b11, 32'h28, 2'b00, 1'b0);
    tick();
    drive(2'b11, 32'h30, 2'b00, 1'b0);
    tick();
    chk("pre_flush_count", 32'(fq.count), 32'd5);
    drive(2'b11, 32'h38, 2'b11, 1'b1);
    #1;
    chk("flush_cycle_can_proceed", 32'(fq.can_proceed), 32'd3);
    tick();
    chk("post_flush_count", 32'(fq.count), 32'd0);
    chk("post_flush_out_valid", 32'(fq.out_valid), 32'd0);
    drive(2'b01, 32'h100, 2'b00, 1'b0);
    tick();
    chk("after_flush_count", 32'(fq.count), 32'd1);
    chk("after_flush_pc0", fq.out_pc[0], 32'h100);
    drive(2'b00, 32'h0, 2'b01, 1'b0);
    tick();
    chk("empty_again_count", 32'(fq.count), 32'd0);

    // Empty queue: same-cycle forward with the bypass, one cycle later without
    drive(2'b11, 32'h40, 2'b11, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_out_valid", 32'(fq.out_valid), 32'd3);
    chk("byp_pc0", fq.out_pc[0], 32'h40);
    chk("byp_pc1", fq.out_pc[1], 32'h44);
    tick();
    chk("byp_count", 32'(fq.count), 32'd0);
`else
    chk("lat_out_valid_same", 32'(fq.out_valid), 32'd0);
    tick();
    drive(2'b00, 32'h0, 2'b11, 1'b0);
    #1;
    chk("lat_count", 32'(fq.count), 32'd2);
    chk("lat_out_valid_next", 32'(fq.out_valid), 32'd3);
    chk("lat_pc0", fq.out_pc[0], 32'h40);
    tick();
    chk("lat_drained", 32'(fq.count), 32'd0);
`endif

    // Ordered stream across several pointer wraps
    exp_out = 32'h200;
    next_in = 32'h200;
    for (int c = 0; c < 24; c++) begin
      drive(2'b11, next_in, 2'b11, 1'b0);
      #1;
      adv = int'(fq.can_proceed[0]) + int'(fq.can_proceed[1]);
      if (fq.out_valid[0]) begin
        chk("stream_pc0", fq.out_pc[0], exp_out);
        chk("stream_instr0", fq.out_instr[0], instr_of(exp_out));
        exp_out = exp_out + 32'd4;
        popped++;
        if (fq.out_valid[1]) begin
          chk("stream_pc1", fq.out_pc[1], exp_out);
          exp_out = exp_out + 32'd4;
          popped++;
        end
      end
      tick();
      next_in = next_in + 32'(4 * adv);
    end
    drive(2'b00, 32'h0, 2'b11, 1'b0);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fq.out_valid[0]) begin
        chk("drain_pc0", fq.out_pc[0], exp_out);
        exp_out = exp_out + 32'd4;
        popped++;
        if (fq.out_valid[1]) begin
          chk("drain_pc1", fq.out_pc[1], exp_out);
          exp_out = exp_out + 32'd4;
          popped++;
        end
      end
      tick();
    end
    chk("stream_empty", 32'(fq.count), 32'd0);
    chk("stream_all_out", exp_out, next_in);
    chk("stream_enough", 32'(popped >= 3 * DEPTH), 32'd1);

    // Asynchronous reset in mid-stream
    drive(2'b11, 32'h500, 2'b00, 1'b0);
    tick();
    chk("pre_reset_count", 32'(fq.count), 32'd2);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(fq.count), 32'd0);
    chk("mid_rst_out_valid", 32'(fq.out_valid), 32'd0);
    chk("mid_rst_can_proceed", 32'(fq.can_proceed), 32'd3);
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_rst_count", 32'(fq.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
